// File: rtl/multisend_arbiter_if.sv
// Signal bundle between the requesters / multisend transmitter and the arbiter.
// The slave view is the arbiter; the master view is everything around it.
interface multisend_arbiter_if;
    logic [3:0]  req;
    logic [31:0] num0;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [31:0] num3;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] send_num;
    logic        send_en;
    logic        send_done;
    logic        busy;

    modport slave (
        input  req, num0, num1, num2, num3, send_done,
        output grant, ack, err, send_num, send_en, busy
    );

    modport master (
        output req, num0, num1, num2, num3, send_done,
        input  grant, ack, err, send_num, send_en, busy
    );
endinterface

// File: rtl/multisend_arbiter.sv
// Round-robin owner of the single multisend transmitter: grants one of four
// requesters, runs its frame, returns ack or timeout err, then idles for a gap.
module multisend_arbiter #(
    parameter int unsigned GAP_CYCLES     = 1200000,
    parameter int unsigned TIMEOUT_CYCLES = 24000000
) (
    input  logic               hwclk,
    input  logic               rst_n,
    multisend_arbiter_if.slave bus
);
    localparam logic [31:0] GAP_LOAD    = (GAP_CYCLES == 0) ? 32'd1 : 32'(GAP_CYCLES);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t      state_q;
    logic [1:0]  ptr_q;
    logic [1:0]  gidx_q;
    logic        seen_low_q;
    logic [31:0] tcnt_q;
    logic [31:0] gcnt_q;
    logic [3:0]  grant_q;
    logic [3:0]  ack_q;
    logic [3:0]  err_q;
    logic [31:0] send_num_q;
    logic        send_en_q;

    logic [3:0]  rot_req;
    logic [1:0]  pick_off;
    logic [1:0]  pick_idx;
    logic        pick_valid;
    logic [31:0] num_arr [4];
    logic [31:0] tcnt_d;
    logic [31:0] gcnt_d;
    logic        done_hit;
    logic        timeout_hit;

    assign num_arr[0] = bus.num0;
    assign num_arr[1] = bus.num1;
    assign num_arr[2] = bus.num2;
    assign num_arr[3] = bus.num3;

    // Requests rotated so that bit 0 is the requester at ptr_q.
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
        assign rot_req[gi] = bus.req[ptr_q + 2'(gi)];
    end

    always_comb begin
        pick_off = 2'd3;
        if (rot_req[0])      pick_off = 2'd0;
        else if (rot_req[1]) pick_off = 2'd1;
        else if (rot_req[2]) pick_off = 2'd2;
    end

    assign pick_idx    = ptr_q + pick_off;
    assign pick_valid  = |bus.req;
    assign tcnt_d      = tcnt_q + 32'd1;
    assign gcnt_d      = gcnt_q - 32'd1;
    // done is stale from the previous frame until it has been seen low once
    assign done_hit    = bus.send_done && seen_low_q;
    assign timeout_hit = (tcnt_d == TIMEOUT_LIM);

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            gidx_q     <= 2'd0;
            seen_low_q <= 1'b0;
            tcnt_q     <= 32'd0;
            gcnt_q     <= 32'd0;
            grant_q    <= 4'd0;
            ack_q      <= 4'd0;
            err_q      <= 4'd0;
            send_num_q <= 32'd0;
            send_en_q  <= 1'b0;
        end else begin
            ack_q <= 4'd0;
            err_q <= 4'd0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q    <= 4'b0001 << pick_idx;
                        gidx_q     <= pick_idx;
                        send_num_q <= num_arr[pick_idx];
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    send_en_q  <= 1'b1;
                    seen_low_q <= 1'b0;
                    tcnt_q     <= 32'd0;
                    state_q    <= SEND;
                end
                SEND: begin
                    tcnt_q <= tcnt_d;
                    if (!bus.send_done) begin
                        seen_low_q <= 1'b1;
                    end
                    if (done_hit || timeout_hit) begin
                        if (done_hit) ack_q <= grant_q;
                        else          err_q <= grant_q;
                        send_en_q <= 1'b0;
                        grant_q   <= 4'd0;
                        gcnt_q    <= GAP_LOAD;
                        ptr_q     <= gidx_q + 2'd1;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gcnt_q <= 32'd1) begin
                        state_q <= IDLE;
                    end else begin
                        gcnt_q <= gcnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.send_num = send_num_q;
    assign bus.send_en  = send_en_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: doc/multisend_arbiter.md
# multisend_arbiter

Round-robin scheduler sharing the single `multisend` transmitter between four requesters (e.g. code-entry echo, lock status, error codes, debug). Latches the granted requester's number, drives the transmitter's `num`/`enabled` pair, and detects completion on `done`. Returns a one-cycle ack, or a one-cycle error on timeout, to the requester. Enforces an idle gap between transmissions so the receiving side sees them as separate frames.

## Interface
- `GAP_CYCLES`, 1200000: idle cycles with `send_en` low between transmissions (0.1 s at 12 MHz); a value of 0 is treated as 1.
- `TIMEOUT_CYCLES`, 24000000: maximum SEND duration before abort (2 s).
- `hwclk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: level requests; bit i is held high until `ack[i]` or `err[i]`.
- `num0`..`num3` in 32 each: payload of requester i; must be stable while `req[i]` is high.
- `grant` out 4: one-hot; identifies the requester currently owning the transmitter.
- `ack` out 4: one-cycle pulse when requester i's transmission completes.
- `err` out 4: one-cycle pulse when requester i's transmission times out.
- `send_num` out 32: to `multisend.num`.
- `send_en` out 1: to `multisend.enabled`; a rising edge starts a transmission.
- `send_done` in 1: from `multisend.done`.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- The state machine has four states: IDLE, LOAD, SEND and GAP.
- **IDLE**
  - If `req` ≠ 0, select the first set bit searching from `ptr`, then `ptr+1`, wrapping modulo 4.
  - Set `grant` one-hot for the selected requester, register its `numN` into `send_num`, and go to LOAD.
- **LOAD**
  - Lasts one cycle; `send_num` is stable here.
  - Set `send_en`=1, clear `seen_low`, clear the timeout counter, and go to SEND.
- **SEND**
  - `send_en` is held at 1 and the timeout counter increments every cycle.
  - `seen_low` is set the first cycle `send_done`=0 is sampled. `multisend.done` stays high from the previous frame until the new frame starts, so `send_done` is ignored while `seen_low`=0.
  - Completion is `send_done`=1 with `seen_low`=1. On completion: pulse `ack[g]`, drop `send_en`, drop `grant`, load the gap counter, set `ptr`=g+1 mod 4, and go to GAP.
  - Timeout is reached when the counter equals `TIMEOUT_CYCLES`. On timeout: pulse `err[g]`, drop `send_en`/`grant`, advance `ptr` the same way, and go to GAP.
  - If completion and timeout occur in the same cycle, completion wins (`ack`, not `err`).
- **GAP**
  - `send_en`=0. Count down `max(GAP_CYCLES,1)` cycles, then go to IDLE.
  - Requests arriving during GAP wait; they are arbitrated in IDLE.
- If `req[g]` drops during LOAD or SEND, the transmission is not aborted and the ack/err is still pulsed.
- `ptr` only changes at SEND exit, so a requester holding `req` continuously cannot starve the others.
- Counters are 32-bit unsigned and do not wrap within the parameter range.

## Timing
- **Reset:** while `rst_n`=0, all outputs are 0 immediately (asynchronous): `grant`, `ack`, `err`, `send_num`, `send_en`, `busy`. State = IDLE, `ptr`=0, `seen_low`=0, counters = 0.
- **Reset mid-SEND:** `send_en` falls asynchronously, no ack/err is emitted, and the request is re-arbitrated after release.
- **Request to start:** `req` sampled in IDLE at edge t. At t+1, `grant` and `send_num` are valid and `busy`=1. At t+2, `send_en`=1.
- **Completion:** completion sampled at edge c. At c+1, `ack`=1 for one cycle and `send_en`=0. At c+1+max(GAP_CYCLES,1), state returns to IDLE.
- **Back-to-back frames:** the minimum spacing between consecutive `send_en` rising edges is frame length + GAP + 3 cycles.
- `ack`/`err` are never asserted for more than one cycle and never together. `grant` has at most one bit set.

## Test plan
Bench parameters: `GAP_CYCLES`=4, `TIMEOUT_CYCLES`=50, with a behavioural `multisend` model asserting done 20 cycles after the `enabled` rise.

- Single request: `req`=0001, `num0`=0x00012345 → `grant`=0001 at t+1, `send_num`=0x00012345, `send_en` rises at t+2, `ack`=0001 for one cycle 21 cycles later, `busy` falls 4 cycles after `ack`.
- Round-robin: `req`=1111 held after reset → grant order 0001, 0010, 0100, 1000, 0001. Repeated with `req`=0101 → order 0001, 0100, 0001.
- Stale done: model holds `send_done`=1 at entry to SEND for 2 cycles, then low, then high at cycle 20 → no early `ack`; `ack` only after the low-then-high sequence.
- Timeout: model never asserts `send_done` → `err` pulse for the granted requester 50 cycles after SEND entry, no `ack`, `send_en` low, `ptr` advanced.
- Reset mid-send: `rst_n` low during SEND → `send_en`/`grant`/`busy` are 0 in the same cycle. After release with `req` still high → fresh LOAD starting from requester 0.
- Request drop: `req[2]` falls during SEND → transmission finishes and `ack`=0100 is still pulsed.
